// File: rtl/mm_arb_pkg.sv
// Shared types for the Montgomery core arbiter.
// The FSM states and the bridge BRAM data width.
package mm_arb_pkg;

   typedef enum logic [1:0] {
      IDLE,
      OWN,
      RUN,
      RESULT
   } arb_state_e;

   localparam int BRAM_DW = 17;

endpackage

// File: rtl/mm_core_arbiter_if.sv
// Core-side bundle: the bridge BRAM port B and the core start/done strobes.
// The arbiter drives it as master, and the multiplier top is the slave.
interface mm_core_arbiter_if #(
   parameter int ADDR_W = 32
);
   import mm_arb_pkg::*;

   logic [ADDR_W-1:0]  bram_addr_o;
   logic [BRAM_DW-1:0] bram_din_o;
   logic               bram_we_o;
   logic               bram_en_o;
   logic [BRAM_DW-1:0] bram_dout_i;
   logic               mm_start_o;
   logic               mm_done_i;

   modport master (
      output bram_addr_o, bram_din_o, bram_we_o, bram_en_o, mm_start_o,
      input  bram_dout_i, mm_done_i
   );

   modport slave (
      input  bram_addr_o, bram_din_o, bram_we_o, bram_en_o, mm_start_o,
      output bram_dout_i, mm_done_i
   );

endinterface

// File: rtl/rr_pick.sv
// Round-robin first-one finder.
// It scans upward from the pointer and wraps modulo N.
module rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] ptr_i,
   output logic [N-1:0]  gnt_o,
   output logic [IW-1:0] idx_o,
   output logic          vld_o
);

   logic [IW:0] s;

   always_comb begin
      gnt_o = '0;
      idx_o = '0;
      vld_o = 1'b0;
      s     = '0;
      for (int i = 0; i < N; i++) begin
         s = {1'b0, ptr_i} + (IW+1)'(i);
         if (s >= (IW+1)'(N))
            s = s - (IW+1)'(N);
         if (!vld_o && req_i[s[IW-1:0]]) begin
            vld_o            = 1'b1;
            gnt_o[s[IW-1:0]] = 1'b1;
            idx_o            = s[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/mm_core_arbiter.sv
// Round-robin sharing of one Montgomery core and its bridge BRAM port.
// The winner owns the port until it releases, and every run is watchdogged.
module mm_core_arbiter
   import mm_arb_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                      clock_i,
   input  logic                      reset_n_i,
   input  logic [N_REQ-1:0]          req_i,
   input  logic [N_REQ-1:0]          go_i,
   output logic [N_REQ-1:0]          grant_o,
   output logic [N_REQ-1:0]          done_o,
   output logic [N_REQ-1:0]          err_o,
   input  logic [N_REQ*ADDR_W-1:0]   rq_bram_addr_i,
   input  logic [N_REQ*BRAM_DW-1:0]  rq_bram_din_i,
   input  logic [N_REQ-1:0]          rq_bram_we_i,
   input  logic [N_REQ-1:0]          rq_bram_en_i,
   output logic [BRAM_DW-1:0]        rq_bram_dout_o,
   mm_core_arbiter_if.master         core
);

   localparam int IW = $clog2(N_REQ);
   localparam int WW = $clog2(TIMEOUT_CYCLES);
   localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYCLES - 1);

   arb_state_e         state_q, state_d;
   logic [IW-1:0]      ptr_q, ptr_d;
   logic [IW-1:0]      owner_q, owner_d;
   logic [N_REQ-1:0]   grant_q, grant_d;
   logic [N_REQ-1:0]   done_q, done_d;
   logic [N_REQ-1:0]   err_q, err_d;
   logic               start_q, start_d;
   logic [WW-1:0]      wd_q, wd_d;

   logic [N_REQ-1:0]   pick_gnt;
   logic [IW-1:0]      pick_idx;
   logic               pick_vld;
   logic [IW-1:0]      nxt_ptr;

   rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
      .req_i (req_i),
      .ptr_i (ptr_q),
      .gnt_o (pick_gnt),
      .idx_o (pick_idx),
      .vld_o (pick_vld)
   );

   assign nxt_ptr = (owner_q == IW'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

   // Release takes priority over go, so a run never starts on a dying grant.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      grant_d = grant_q;
      done_d  = '0;
      err_d   = '0;
      start_d = 1'b0;
      wd_d    = wd_q;
      unique case (state_q)
         IDLE: begin
            if (pick_vld) begin
               grant_d = pick_gnt;
               owner_d = pick_idx;
               state_d = OWN;
            end
         end
         OWN, RESULT: begin
            if (!req_i[owner_q]) begin
               grant_d = '0;
               ptr_d   = nxt_ptr;
               state_d = IDLE;
            end else if (go_i[owner_q]) begin
               start_d = 1'b1;
               wd_d    = '0;
               state_d = RUN;
            end
         end
         RUN: begin
            if (core.mm_done_i) begin
               done_d  = grant_q;
               state_d = RESULT;
            end else if (wd_q == WD_LAST) begin
               err_d   = grant_q;
               state_d = RESULT;
            end else begin
               wd_d = wd_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q <= IDLE;
         ptr_q   <= '0;
         owner_q <= '0;
         grant_q <= '0;
         done_q  <= '0;
         err_q   <= '0;
         start_q <= 1'b0;
         wd_q    <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         grant_q <= grant_d;
         done_q  <= done_d;
         err_q   <= err_d;
         start_q <= start_d;
         wd_q    <= wd_d;
      end
   end

   logic               mux_en;
   logic [ADDR_W-1:0]  mux_addr;
   logic [BRAM_DW-1:0] mux_din;
   logic               mux_we;
   logic               mux_en_o;

   assign mux_en = (state_q == OWN) || (state_q == RESULT);

   // The grant is one-hot, so an AND-OR mux selects the owner's lane.
   always_comb begin
      mux_addr = '0;
      mux_din  = '0;
      mux_we   = 1'b0;
      mux_en_o = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (mux_en && grant_q[i]) begin
            mux_addr = mux_addr | rq_bram_addr_i[i*ADDR_W +: ADDR_W];
            mux_din  = mux_din  | rq_bram_din_i[i*BRAM_DW +: BRAM_DW];
            mux_we   = mux_we   | rq_bram_we_i[i];
            mux_en_o = mux_en_o | rq_bram_en_i[i];
         end
      end
   end

   assign core.bram_addr_o = mux_addr;
   assign core.bram_din_o  = mux_din;
   assign core.bram_we_o   = mux_we;
   assign core.bram_en_o   = mux_en_o;
   assign core.mm_start_o  = start_q;
   assign rq_bram_dout_o   = core.bram_dout_i;

   assign grant_o = grant_q;
   assign done_o  = done_q;
   assign err_o   = err_q;

endmodule

// File: doc/mm_core_arbiter.md
Name: mm_core_arbiter

Overview:
- Shares one Montgomery multiplier core (the BRAM-bridged FIOS top with start/done) and its bridge BRAM operand port among N_REQ requesters.
- Arbitrates round-robin and grants one requester exclusive use of the bridge BRAM port. That requester loads p'_0, a, b and p, then asks for a run.
- The block pulses the core start, waits for done with a watchdog, and holds the grant until the requester has read the result and released.
- Sits between the multiplier top and the key-schedule/exponentiation masters.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ADDR_W, 32, bridge BRAM address width.
- TIMEOUT_CYCLES, 4096, cycles allowed between core start and core done before abort (>=2).

Ports:
- clock_i  in  1  system clock
- reset_n_i  in  1  asynchronous active-low reset
- req_i  in  N_REQ  request bus; level, held until released
- go_i  in  N_REQ  per-requester run request; 1-cycle pulse
- grant_o  out  N_REQ  one-hot ownership
- done_o  out  N_REQ  1-cycle pulse to owner: result valid in BRAM
- err_o  out  N_REQ  1-cycle pulse to owner: watchdog abort
- rq_bram_addr_i  in  N_REQ*ADDR_W  per-requester BRAM address
- rq_bram_din_i  in  N_REQ*17  per-requester write data
- rq_bram_we_i  in  N_REQ  per-requester write enable
- rq_bram_en_i  in  N_REQ  per-requester enable
- rq_bram_dout_o  out  17  shared read data, broadcast to all requesters
- bram_addr_o  out  ADDR_W  to bridge BRAM port B
- bram_din_o  out  17  to bridge BRAM port B
- bram_we_o  out  1  to bridge BRAM port B
- bram_en_o  out  1  to bridge BRAM port B
- bram_dout_i  in  17  from bridge BRAM port B
- mm_start_o  out  1  core start pulse
- mm_done_i  in  1  core done pulse

Behaviour:
Reset:
- All outputs 0; state IDLE; round-robin pointer = 0; watchdog counter = 0.

States:
- IDLE: computes the winner as the first set req_i at or after the pointer, wrapping modulo N_REQ. Registers grant_o one-hot on the next edge and moves to OWN. No request: stays in IDLE with grant_o = 0.
- OWN: the owner's BRAM signals pass combinationally to bram_*_o. Non-owners' we/en are ignored, and bram_*_o = 0 when no owner. When go_i[owner] = 1, the block asserts mm_start_o for exactly 1 cycle (registered, the cycle after go), forces bram_en_o/bram_we_o = 0, and moves to RUN. go_i from non-owners is ignored.
- RUN: BRAM mux is disabled (port quiet while the core owns the bridge). The watchdog counts from 0.
  - mm_done_i = 1: done_o[owner] pulses next cycle → RESULT.
  - Counter reaches TIMEOUT_CYCLES-1 without done: err_o[owner] pulses → RESULT.
  - mm_done_i arriving on the timeout cycle counts as done, with no error.
- RESULT: mux re-enabled for readback. A further go_i starts a new run (→ RUN, counter cleared). When req_i[owner] falls: grant_o = 0 next cycle, pointer = owner+1 mod N_REQ → IDLE.

Boundary conditions:
- req_i[owner] falling in OWN: release immediately with no run.
- req_i[owner] falling in RUN: ignored until the run ends. The owner keeps its grant until done/err, then releases on the following cycle if req is still low.
- go_i and req_i falling in the same cycle in OWN: release wins, no start.
- mm_done_i outside RUN: ignored.
- One IDLE cycle between owners always (no back-to-back grant); fairness bound is N_REQ-1 intervening grants.
- rq_bram_dout_o = bram_dout_i at all times; read latency is that of the BRAM.
- Reset asserted mid-RUN: all outputs clear asynchronously. The core is not aborted by this block and must share the reset.

Decomposition:
- Package mm_arb_pkg: state enum (IDLE, OWN, RUN, RESULT) and BRAM data width constant 17.
- One sub-module, rr_pick: combinational round-robin first-one finder (req vector, pointer → one-hot, valid).
- Datapath mux and FSM stay in the top.

Test Plan:
- Single requester: req_i = 0001, go at OWN+3 → mm_start_o pulse 1 cycle after go. mm_done_i after 50 cycles → done_o = 0001 next cycle. Release → grant_o = 0 next cycle.
- Contention: req_i = 1111 held, each owner releases after done → grants in order 0001, 0010, 0100, 1000, 0001, with 1 IDLE cycle between grants.
- Pointer wrap: pointer = 3 after owner 2, req_i = 0101 → grant_o = 0001.
- Watchdog: TIMEOUT_CYCLES = 16, no mm_done_i → err_o[owner] exactly 16 cycles after start. mm_done_i on cycle 16 instead → done_o, no err_o.
- Isolation: non-owner drives we = 1, addr = 5, din = 0x1ABCD while owner is idle on the port → bram_we_o = 0. In RUN, owner we = 1 → bram_we_o = 0.
- Reset mid-RUN: reset_n_i low → grant_o, mm_start_o, done_o, bram_en_o = 0 immediately; after reset the first grant goes to requester 0.
